// File: rtl/mem_if_pkg.sv
// ----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the mem_master slice:
//   - req_size / req_burst encodings
//   - beat-count lookup for a burst code (1/4/8/16)
//   - default START_ADDRESS and MEM_SIZE
//   - the mem_master FSM state enum
// No ports (package).
// ----------------------------------------------------------------------------
package mem_if_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    BURST_1  = 2'b00,
    BURST_4  = 2'b01,
    BURST_8  = 2'b10,
    BURST_16 = 2'b11
  } burst_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BEAT  = 3'd2,
    WRESP = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam logic [31:0] START_ADDRESS_DEF = 32'h8002_0000;
  localparam int          MEM_SIZE_DEF      = 1048578;

  // Number of load beats encoded by a burst code.
  function automatic logic [4:0] beat_count(input logic [1:0] burst);
    logic [4:0] n;
    case (burst)
      BURST_1:  n = 5'd1;
      BURST_4:  n = 5'd4;
      BURST_8:  n = 5'd8;
      BURST_16: n = 5'd16;
      default:  n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_master_if.sv
// ----------------------------------------------------------------------------
// mem_master_if
// Bundles the request/response channel and the memory-side bus of mem_master.
// Parameters: ADDRESS_SIZE, DATA_SIZE.
// Modports:
//   master - the mem_master view: drives req_ready, rsp_*, mem_* (except
//            mem_d_out / mem_busy), samples req_* and memory read data.
//   slave  - the environment view (requester + memory), the reverse.
// ----------------------------------------------------------------------------
interface mem_master_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
) ();

  // request / response channel
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0]    req_wdata;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [1:0]              req_burst;
  logic                    rsp_valid;
  logic [DATA_SIZE-1:0]    rsp_rdata;
  logic                    rsp_last;
  logic                    rsp_err;

  // memory side
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0]    mem_d_in;
  logic [DATA_SIZE-1:0]    mem_d_out;
  logic [1:0]              mem_acc_size;
  logic                    mem_wren;
  logic                    mem_enable;
  logic                    mem_byteOnly;
  logic                    mem_ubyte;
  logic                    mem_halfWord;
  logic                    mem_outputNop;
  logic                    mem_busy;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_size, req_unsigned,
           req_burst, mem_d_out, mem_busy,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
           mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_enable,
           mem_byteOnly, mem_ubyte, mem_halfWord, mem_outputNop
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_size, req_unsigned,
           req_burst, mem_d_out, mem_busy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
           mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_enable,
           mem_byteOnly, mem_ubyte, mem_halfWord, mem_outputNop
  );

endinterface

// File: rtl/mem_req_check.sv
// ----------------------------------------------------------------------------
// mem_req_check
// Purely combinational legality check of an incoming request.
// Ports:
//   addr  in  ADDRESS_SIZE  request byte address
//   wr    in  1             1 = store
//   size  in  2             access size code
//   burst in  2             burst code
//   err   out 1             request must be rejected
// Rejects: address below START_ADDRESS, span (beats*4 bytes) past the end of
// memory, reserved size code, stores with a burst code other than single.
// Optional: with MEM_MASTER_ALIGN_CHECK_EN defined, misaligned half/word
// accesses are rejected as well; otherwise they pass through unchanged.
// ----------------------------------------------------------------------------
module mem_req_check
  import mem_if_pkg::*;
#(
  parameter int                      ADDRESS_SIZE  = 32,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = START_ADDRESS_DEF,
  parameter int                      MEM_SIZE      = MEM_SIZE_DEF
) (
  input  logic [ADDRESS_SIZE-1:0] addr,
  input  logic                    wr,
  input  logic [1:0]              size,
  input  logic [1:0]              burst,
  output logic                    err
);

  // One extra bit so offset + span can never wrap.
  localparam int                    AW1       = ADDRESS_SIZE + 1;
  localparam logic [ADDRESS_SIZE:0] START_EXT = {1'b0, START_ADDRESS};
  localparam logic [ADDRESS_SIZE:0] LIMIT     = AW1'(MEM_SIZE);

  logic [ADDRESS_SIZE:0] addr_ext_s;
  logic [ADDRESS_SIZE:0] end_off_s;
  logic                  below_s;
  logic                  over_s;
  logic                  size_bad_s;
  logic                  store_burst_s;
  logic                  misalign_s;

  // Range, size, burst and (optionally) alignment checks.
  always_comb begin
    addr_ext_s    = {1'b0, addr};
    below_s       = (addr_ext_s < START_EXT);
    // The span is always counted in 4-byte beats, whatever the access size.
    end_off_s     = (addr_ext_s - START_EXT) + AW1'({beat_count(burst), 2'b00});
    over_s        = (end_off_s > LIMIT);
    size_bad_s    = (size == SIZE_RSVD);
    store_burst_s = wr && (burst != BURST_1);
`ifdef MEM_MASTER_ALIGN_CHECK_EN
    misalign_s    = ((size == SIZE_HALF) && (addr[0] != 1'b0)) ||
                    ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
`else
    misalign_s    = 1'b0;
`endif
    err = below_s || over_s || size_bad_s || store_burst_s || misalign_s;
  end

endmodule

// File: rtl/mem_master.sv
// ----------------------------------------------------------------------------
// mem_master
// Turns single load/store requests (and load bursts of 4/8/16 beats) into
// accesses on a registered-read memory and returns one response beat per
// load word, or a single completion/error pulse.
// Ports:
//   clk    in  1  clock, all state on the rising edge
//   rst_n  in  1  asynchronous active-low reset
//   bus    mem_master_if.master  request/response channel and memory bus
// Timing: acceptance edge E0 -> ISSUE (mem_enable) -> memory registers the
// first word at E1 -> first response beat visible after E1, sampled at E2.
// Error responses are visible right after E0 and never touch memory.
// Optional: MEM_MASTER_ALIGN_CHECK_EN enables misalignment rejection inside
// mem_req_check.
// ----------------------------------------------------------------------------
module mem_master
  import mem_if_pkg::*;
#(
  parameter int                      ADDRESS_SIZE  = 32,
  parameter int                      DATA_SIZE     = 32,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = START_ADDRESS_DEF,
  parameter int                      MEM_SIZE      = MEM_SIZE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_master_if.master bus
);

  state_e state_r;
  state_e next_state_s;

  logic [3:0] beat_cnt_r;
  logic [3:0] beat_cnt_nx_s;
  logic [3:0] beat_last_r;
  logic [4:0] beats_s;
  logic       accept_s;
  logic       chk_err_s;

  logic req_ready_r,  req_ready_nx_s;
  logic rsp_valid_r,  rsp_valid_nx_s;
  logic rsp_last_r,   rsp_last_nx_s;
  logic rsp_err_r,    rsp_err_nx_s;
  logic rsp_beat_r,   rsp_beat_nx_s;
  logic mem_enable_r, mem_enable_nx_s;

  logic [ADDRESS_SIZE-1:0] mem_addr_r;
  logic [DATA_SIZE-1:0]    mem_d_in_r;
  logic [1:0]              mem_acc_size_r;
  logic                    mem_wren_r;
  logic                    mem_byte_only_r;
  logic                    mem_ubyte_r;
  logic                    mem_half_word_r;

  assign accept_s = bus.req_valid && req_ready_r;
  assign beats_s  = beat_count(bus.req_burst);

  mem_req_check #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .START_ADDRESS(START_ADDRESS),
    .MEM_SIZE     (MEM_SIZE)
  ) u_check (
    .addr (bus.req_addr),
    .wr   (bus.req_wr),
    .size (bus.req_size),
    .burst(bus.req_burst),
    .err  (chk_err_s)
  );

  // State register and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      beat_cnt_r <= 4'd0;
    end else begin
      state_r    <= next_state_s;
      beat_cnt_r <= beat_cnt_nx_s;
    end
  end

  // Next-state and next beat-count logic.
  always_comb begin
    next_state_s  = state_r;
    beat_cnt_nx_s = 4'd0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = chk_err_s ? ERR : ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        next_state_s = mem_wren_r ? WRESP : BEAT;
      end
      BEAT: begin
        if (beat_cnt_r == beat_last_r) begin
          next_state_s = IDLE;
        end else begin
          next_state_s  = BEAT;
          beat_cnt_nx_s = beat_cnt_r + 4'd1;
        end
      end
      WRESP:   next_state_s = IDLE;
      ERR:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so every control output is a flop.
  always_comb begin
    req_ready_nx_s  = (next_state_s == IDLE);
    mem_enable_nx_s = (next_state_s == ISSUE);
    rsp_beat_nx_s   = (next_state_s == BEAT);
    rsp_err_nx_s    = (next_state_s == ERR);
    rsp_valid_nx_s  = 1'b0;
    rsp_last_nx_s   = 1'b0;
    case (next_state_s)
      BEAT: begin
        rsp_valid_nx_s = 1'b1;
        rsp_last_nx_s  = (beat_cnt_nx_s == beat_last_r);
      end
      WRESP, ERR: begin
        rsp_valid_nx_s = 1'b1;
        rsp_last_nx_s  = 1'b1;
      end
      default: begin
        rsp_valid_nx_s = 1'b0;
        rsp_last_nx_s  = 1'b0;
      end
    endcase
  end

  // Output registers; req_ready stays low through reset and rises one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_last_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_beat_r   <= 1'b0;
      mem_enable_r <= 1'b0;
    end else begin
      req_ready_r  <= req_ready_nx_s;
      rsp_valid_r  <= rsp_valid_nx_s;
      rsp_last_r   <= rsp_last_nx_s;
      rsp_err_r    <= rsp_err_nx_s;
      rsp_beat_r   <= rsp_beat_nx_s;
      mem_enable_r <= mem_enable_nx_s;
    end
  end

  // Request capture at acceptance; held until the next accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r      <= '0;
      mem_d_in_r      <= '0;
      mem_acc_size_r  <= 2'b00;
      mem_wren_r      <= 1'b0;
      mem_byte_only_r <= 1'b0;
      mem_ubyte_r     <= 1'b0;
      mem_half_word_r <= 1'b0;
      beat_last_r     <= 4'd0;
    end else if (accept_s) begin
      mem_addr_r      <= bus.req_addr;
      mem_d_in_r      <= bus.req_wdata;
      mem_acc_size_r  <= bus.req_burst;
      mem_wren_r      <= bus.req_wr;
      mem_byte_only_r <= (bus.req_size == SIZE_BYTE);
      mem_half_word_r <= (bus.req_size == SIZE_HALF);
      mem_ubyte_r     <= bus.req_unsigned && (bus.req_size == SIZE_BYTE) && !bus.req_wr;
      // 16 beats encodes as 5'b10000; the 4-bit wrap gives 15 as required.
      beat_last_r     <= beats_s[3:0] - 4'd1;
    end else begin
      mem_addr_r      <= mem_addr_r;
      mem_d_in_r      <= mem_d_in_r;
      mem_acc_size_r  <= mem_acc_size_r;
      mem_wren_r      <= mem_wren_r;
      mem_byte_only_r <= mem_byte_only_r;
      mem_ubyte_r     <= mem_ubyte_r;
      mem_half_word_r <= mem_half_word_r;
      beat_last_r     <= beat_last_r;
    end
  end

  assign bus.req_ready     = req_ready_r;
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_last      = rsp_last_r;
  assign bus.rsp_err       = rsp_err_r;
  // Memory data is already registered by the memory; pass it through only on beats.
  assign bus.rsp_rdata     = rsp_beat_r ? bus.mem_d_out : '0;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_d_in      = mem_d_in_r;
  assign bus.mem_acc_size  = mem_acc_size_r;
  assign bus.mem_wren      = mem_wren_r;
  assign bus.mem_enable    = mem_enable_r;
  assign bus.mem_byteOnly  = mem_byte_only_r;
  assign bus.mem_ubyte     = mem_ubyte_r;
  assign bus.mem_halfWord  = mem_half_word_r;
  assign bus.mem_outputNop = 1'b0;

endmodule

// File: tb/tb_mem_master.sv
// ----------------------------------------------------------------------------
// tb_mem_master
// Directed bench for mem_master with a small byte-array memory model
// (registered read data, burst of 4-byte steps, byte/half/word writes).
// Optional: build with MEM_MASTER_ALIGN_CHECK_EN to expect misalignment errors.
// ----------------------------------------------------------------------------
module tb_mem_master;
  import mem_if_pkg::*;

  logic clk;
  logic rst_n;

  mem_master_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) bus ();

  mem_master dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_d [0:15];

  // memory model state
  logic [7:0]  mem_a [0:255];
  logic [31:0] rd_addr_r;
  logic [4:0]  rd_left_r;
  logic        rd_b_r, rd_ub_r, rd_h_r;

  assign bus.mem_busy = (rd_left_r != 5'd0);

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic b,
                                           input logic ub, input logic h);
    logic [7:0] i0;
    i0 = a[7:0];
    if (b) begin
      return ub ? {24'h0, mem_a[i0]} : {{24{mem_a[i0][7]}}, mem_a[i0]};
    end else if (h) begin
      return {{16{mem_a[i0+8'd1][7]}}, mem_a[i0+8'd1], mem_a[i0]};
    end else begin
      return {mem_a[i0+8'd3], mem_a[i0+8'd2], mem_a[i0+8'd1], mem_a[i0]};
    end
  endfunction

  // Memory model: writes on enable+wren, registered reads with burst stepping.
  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_wren) begin
      mem_a[bus.mem_addr[7:0]] <= bus.mem_d_in[7:0];
      if (!bus.mem_byteOnly) mem_a[bus.mem_addr[7:0] + 8'd1] <= bus.mem_d_in[15:8];
      if (!bus.mem_byteOnly && !bus.mem_halfWord) begin
        mem_a[bus.mem_addr[7:0] + 8'd2] <= bus.mem_d_in[23:16];
        mem_a[bus.mem_addr[7:0] + 8'd3] <= bus.mem_d_in[31:24];
      end
      rd_left_r <= 5'd0;
    end else if (bus.mem_enable) begin
      bus.mem_d_out <= mem_read(bus.mem_addr, bus.mem_byteOnly, bus.mem_ubyte, bus.mem_halfWord);
      rd_addr_r     <= bus.mem_addr + 32'd4;
      rd_left_r     <= beat_count(bus.mem_acc_size) - 5'd1;
      rd_b_r        <= bus.mem_byteOnly;
      rd_ub_r       <= bus.mem_ubyte;
      rd_h_r        <= bus.mem_halfWord;
    end else if (rd_left_r != 5'd0) begin
      bus.mem_d_out <= mem_read(rd_addr_r, rd_b_r, rd_ub_r, rd_h_r);
      rd_addr_r     <= rd_addr_r + 32'd4;
      rd_left_r     <= rd_left_r - 5'd1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and collect its responses (expected load data in exp_d).
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic uns, input logic [1:0] burst,
                         input logic exp_err, input int exp_beats);
    int nb, first_idx, last_i, en_cnt, guard;
    logic err_seen, done;
    logic [31:0] got_d [0:15];
    logic [31:0] iss_addr;
    logic [3:0]  iss_flags;
    logic [3:0]  exp_flags;
    nb = 0; first_idx = 0; last_i = 0; en_cnt = 0; guard = 0;
    err_seen = 1'b0; done = 1'b0; iss_addr = 32'h0; iss_flags = 4'h0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_size = size; bus.req_unsigned = uns; bus.req_burst = burst;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_enable) begin
        en_cnt++;
        iss_addr  = bus.mem_addr;
        iss_flags = {bus.mem_byteOnly, bus.mem_halfWord, bus.mem_ubyte, bus.mem_wren};
      end
      if (bus.rsp_valid) begin
        if (nb == 0) first_idx = i;
        if (nb < 16) got_d[nb] = bus.rsp_rdata;
        err_seen = err_seen | bus.rsp_err;
        nb++;
        last_i = i;
        if (bus.rsp_last) done = 1'b1;
      end
    end
    check_val({tag, " beats"}, nb, exp_beats);
    check_val({tag, " latency"}, first_idx, exp_err ? 32'd1 : 32'd2);
    check_val({tag, " gapless"}, last_i - first_idx + 1, exp_beats);
    check_val({tag, " err"}, {31'd0, err_seen}, {31'd0, exp_err});
    check_val({tag, " enables"}, en_cnt, exp_err ? 32'd0 : 32'd1);
    if (!exp_err) begin
      exp_flags = {size == 2'b00, size == 2'b01, uns && size == 2'b00 && !wr, wr};
      check_val({tag, " mem_addr"}, iss_addr, addr);
      check_val({tag, " mem_flags"}, {28'd0, iss_flags}, {28'd0, exp_flags});
      if (!wr) begin
        for (int k = 0; k < exp_beats && k < nb && k < 16; k++) begin
          check_val($sformatf("%s data%0d", tag, k), got_d[k], exp_d[k]);
        end
      end
    end
  endtask

  initial begin
    int nb, guard, vcnt;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_burst = 2'b00;

    // reset state
    #3;
    check_val("rst ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rst rsp", {29'd0, bus.rsp_valid, bus.rsp_last, bus.rsp_err}, 32'd0);
    check_val("rst mem", {30'd0, bus.mem_enable, bus.mem_wren}, 32'd0);
    check_val("rst addr", bus.mem_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("ready before edge", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check_val("ready after release", {31'd0, bus.req_ready}, 32'd1);

    // word store then load
    run_txn("st word", 1'b1, 32'h8002_0000, 32'hDEAD_BEEF, 2'b10, 1'b0, 2'b00, 1'b0, 1);
    exp_d[0] = 32'hDEAD_BEEF;
    run_txn("ld word", 1'b0, 32'h8002_0000, 32'h0, 2'b10, 1'b0, 2'b00, 1'b0, 1);

    // byte 8F at offset 3, signed / unsigned loads, then whole word
    run_txn("st byte", 1'b1, 32'h8002_0003, 32'h0000_008F, 2'b00, 1'b0, 2'b00, 1'b0, 1);
    exp_d[0] = 32'hFFFF_FF8F;
    run_txn("ld sbyte", 1'b0, 32'h8002_0003, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0, 1);
    exp_d[0] = 32'h0000_008F;
    run_txn("ld ubyte", 1'b0, 32'h8002_0003, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0, 1);
    exp_d[0] = 32'h8FAD_BEEF;
    run_txn("ld word2", 1'b0, 32'h8002_0000, 32'h0, 2'b10, 1'b0, 2'b00, 1'b0, 1);

    // misaligned half load (bytes BE, AD)
`ifdef MEM_MASTER_ALIGN_CHECK_EN
    run_txn("ld half mis", 1'b0, 32'h8002_0001, 32'h0, 2'b01, 1'b0, 2'b00, 1'b1, 1);
`else
    exp_d[0] = 32'hFFFF_ADBE;
    run_txn("ld half mis", 1'b0, 32'h8002_0001, 32'h0, 2'b01, 1'b0, 2'b00, 1'b0, 1);
`endif

    // 4-beat burst
    for (int k = 0; k < 4; k++) begin
      run_txn($sformatf("st w%0d", k), 1'b1, 32'h8002_0000 + 32'(4 * k), 32'(k + 1),
              2'b10, 1'b0, 2'b00, 1'b0, 1);
      exp_d[k] = 32'(k + 1);
    end
    run_txn("ld burst4", 1'b0, 32'h8002_0000, 32'h0, 2'b10, 1'b0, 2'b01, 1'b0, 4);

    // errors
    run_txn("ld below", 1'b0, 32'h8001_FFFC, 32'h0, 2'b10, 1'b0, 2'b00, 1'b1, 1);
    run_txn("st burst", 1'b1, 32'h8002_0000, 32'h1234_5678, 2'b10, 1'b0, 2'b01, 1'b1, 1);
    run_txn("ld size11", 1'b0, 32'h8002_0000, 32'h0, 2'b11, 1'b0, 2'b00, 1'b1, 1);

    // upper boundary: offset 0xFFFFE + 4 = MEM_SIZE is legal, one more byte is not
    run_txn("st top", 1'b1, 32'h8011_FFFE, 32'h0000_005A, 2'b00, 1'b0, 2'b00, 1'b0, 1);
    exp_d[0] = 32'h0000_005A;
    run_txn("ld top", 1'b0, 32'h8011_FFFE, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0, 1);
    run_txn("ld past", 1'b0, 32'h8011_FFFF, 32'h0, 2'b00, 1'b1, 2'b00, 1'b1, 1);

    // reset during beat 2 of a 16-beat load
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req_wr = 1'b0; bus.req_addr = 32'h8002_0000; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_burst = 2'b11; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    nb = 0; guard = 0;
    while (nb < 2 && guard < 20) begin
      @(negedge clk);
      if (bus.rsp_valid) nb++;
      guard++;
    end
    check_val("b16 beats before rst", nb, 32'd2);
    rst_n = 1'b0;
    #1;
    check_val("midrst rsp", {29'd0, bus.rsp_valid, bus.rsp_last, bus.rsp_err}, 32'd0);
    check_val("midrst rdata", bus.rsp_rdata, 32'h0);
    check_val("midrst ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("midrst mem", {27'd0, bus.mem_enable, bus.mem_wren, bus.mem_byteOnly,
                             bus.mem_halfWord, bus.mem_ubyte}, 32'd0);
    check_val("midrst addr", bus.mem_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ready after midrst", {31'd0, bus.req_ready}, 32'd1);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) vcnt++;
    end
    check_val("no rsp after rst", vcnt, 32'd0);

    // recovery
    exp_d[0] = 32'd2;
    run_txn("ld recover", 1'b0, 32'h8002_0004, 32'h0, 2'b10, 1'b0, 2'b00, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
